// File: rtl/crc32_pcie_checker.sv
// Frame checker for 64-bit beats: CRC-32 (poly 04C11DB7, preset all-ones, MSB first, inverted result).
// Each payload beat is folded into the running CRC, and the EOF beat carries the expected CRC in [31:0].
module crc32_pcie_checker #(
    parameter int unsigned MAX_WORDS = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] data_in,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        in_ready,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic [31:0] crc_calc,
    output logic        proto_err,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
);

    localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [15:0] WORDS_MAX = 16'(MAX_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESULT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_crc, w_crc_nxt;
    logic [15:0] r_words, w_words_nxt;
    logic        r_crc_ok, w_crc_ok_nxt;
    logic        r_crc_err, w_crc_err_nxt;
    logic [31:0] r_crc_calc, w_crc_calc_nxt;
    logic        r_proto_err, w_proto_err_nxt;
    logic [15:0] r_frame_count, w_frame_count_nxt;
    logic [15:0] r_err_count, w_err_count_nxt;
    logic [31:0] w_fold_seed, w_crc_fold, w_crc_final;
    logic        w_accept, w_match;

    function automatic logic [31:0] crc_fold(input logic [31:0] crc, input logic [63:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 64; i++) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[63 - i]) ? CRC_POLY : '0);
        end
        return c;
    endfunction

    assign in_ready    = !rst && (r_state != RESULT);
    assign frame_done  = (r_state == RESULT);
    assign w_accept    = in_valid && in_ready;
    // A SOF beat always folds from the preset, including when it aborts a frame in progress.
    assign w_fold_seed = (r_state == DATA && !in_sof) ? r_crc : CRC_INIT;
    assign w_crc_fold  = crc_fold(w_fold_seed, data_in);
    assign w_crc_final = ~r_crc;
    assign w_match     = (w_crc_final == data_in[31:0]);

    always_comb begin
        w_state_nxt       = r_state;
        w_crc_nxt         = r_crc;
        w_words_nxt       = r_words;
        w_crc_ok_nxt      = r_crc_ok;
        w_crc_err_nxt     = r_crc_err;
        w_crc_calc_nxt    = r_crc_calc;
        w_proto_err_nxt   = 1'b0;
        w_frame_count_nxt = r_frame_count;
        w_err_count_nxt   = r_err_count;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_sof && !in_eof) begin
                        w_crc_nxt   = w_crc_fold;
                        w_words_nxt = 16'd1;
                        w_state_nxt = DATA;
                    end else begin
                        w_proto_err_nxt = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_proto_err_nxt = 1'b1;
                        if (in_eof) begin
                            w_crc_nxt   = CRC_INIT;
                            w_words_nxt = '0;
                            w_state_nxt = IDLE;
                        end else begin
                            w_crc_nxt   = w_crc_fold;
                            w_words_nxt = 16'd1;
                        end
                    end else if (in_eof) begin
                        w_crc_calc_nxt    = w_crc_final;
                        w_crc_ok_nxt      = w_match;
                        w_crc_err_nxt     = !w_match;
                        w_frame_count_nxt = r_frame_count + 16'd1;
                        if (!w_match && r_err_count != '1) begin
                            w_err_count_nxt = r_err_count + 16'd1;
                        end
                        w_state_nxt       = RESULT;
                    end else if (r_words == WORDS_MAX) begin
                        w_proto_err_nxt = 1'b1;
                        w_crc_nxt       = CRC_INIT;
                        w_words_nxt     = '0;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_crc_nxt   = w_crc_fold;
                        w_words_nxt = r_words + 16'd1;
                    end
                end
            end
            RESULT: begin
                w_crc_nxt   = CRC_INIT;
                w_words_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_crc         <= CRC_INIT;
            r_words       <= '0;
            r_crc_ok      <= 1'b0;
            r_crc_err     <= 1'b0;
            r_crc_calc    <= '0;
            r_proto_err   <= 1'b0;
            r_frame_count <= '0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_crc         <= w_crc_nxt;
            r_words       <= w_words_nxt;
            r_crc_ok      <= w_crc_ok_nxt;
            r_crc_err     <= w_crc_err_nxt;
            r_crc_calc    <= w_crc_calc_nxt;
            r_proto_err   <= w_proto_err_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

    assign crc_ok      = r_crc_ok;
    assign crc_err     = r_crc_err;
    assign crc_calc    = r_crc_calc;
    assign proto_err   = r_proto_err;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;

endmodule

// File: doc/crc32_pcie_checker.md
CRC32_PCIE_CHECKER -- requirements
Module: crc32_pcie_checker

Interface
REQ-001 Parameter MAX_WORDS, default 255, maximum payload words per frame (1..65535).
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on rising clk.
REQ-004 data_in  input  64  beat data; payload word, or on the EOF beat CRC in [31:0] with [63:32] ignored.
REQ-005 in_valid  input  1  beat qualifier; a beat is accepted when in_valid=1 and in_ready=1.
REQ-006 in_sof  input  1  first beat of frame, meaningful only with in_valid.
REQ-007 in_eof  input  1  CRC beat of frame, meaningful only with in_valid.
REQ-008 in_ready  output  1  checker can accept a beat this cycle.
REQ-009 frame_done  output  1  one-cycle pulse, frame result valid.
REQ-010 crc_ok  output  1  received CRC matched; valid with frame_done, held until next frame_done.
REQ-011 crc_err  output  1  received CRC mismatched; valid with frame_done, held until next frame_done.
REQ-012 crc_calc  output  32  computed CRC of last completed frame.
REQ-013 proto_err  output  1  one-cycle pulse on framing violation.
REQ-014 frame_count  output  16  completed frames, wraps 0xFFFF->0x0000.
REQ-015 err_count  output  16  CRC-mismatch frames, saturates at 0xFFFF.

Function
REQ-016 CRC SHALL be CRC-32, poly 0x04C11DB7, init 0xFFFFFFFF, non-reflected, data_in[63] processed first, result = bitwise inverse of remainder — identical to the team's crc32PCIe generator.
REQ-017 One 64-bit word SHALL be folded into the running CRC per accepted beat (single-cycle combinational update, registered).
REQ-018 State machine SHALL have states IDLE, DATA, RESULT.
REQ-019 IDLE: accepted beat with in_sof=1 SHALL reset running CRC to init, fold data_in, clear word counter to 1, go to DATA.
REQ-020 IDLE: accepted beat with in_sof=0 SHALL be discarded and pulse proto_err.
REQ-021 DATA: accepted beat with in_eof=0 and in_sof=0 SHALL fold data_in and increment word counter.
REQ-022 DATA: accepted beat with in_eof=1 SHALL compare inverted running CRC to data_in[31:0] without folding it, go to RESULT.
REQ-023 DATA: accepted beat with in_sof=1 SHALL abort current frame, pulse proto_err, restart as REQ-019 in the same cycle.
REQ-024 Accepting a non-EOF beat when word counter = MAX_WORDS SHALL abort frame, pulse proto_err, return to IDLE.
REQ-025 IDLE beat with in_sof=1 and in_eof=1 SHALL pulse proto_err and be discarded (frame requires ≥1 payload word).
REQ-026 RESULT: lasts exactly one cycle; in_ready=0; frame_done=1; crc_ok/crc_err/crc_calc updated; counters updated; next state IDLE.
REQ-027 in_ready SHALL be 1 in IDLE and DATA, 0 in RESULT and during reset.
REQ-028 Latency: frame_done SHALL assert the cycle after the EOF beat is accepted.
REQ-029 Beats with in_valid=0 SHALL leave all state unchanged.
REQ-030 crc_ok and crc_err SHALL never both be 1.

Reset
REQ-031 While rst=1 at a clock edge: state IDLE, running CRC 0xFFFFFFFF, word counter 0, in_ready 0, frame_done 0, crc_ok 0, crc_err 0, crc_calc 0x00000000, proto_err 0, frame_count 0, err_count 0.
REQ-032 rst asserted mid-frame SHALL discard the frame with no frame_done or proto_err pulse.
REQ-033 First beat SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-034 SOF 0x0123456789ABCDEF, word 0xFEDCBA9876543210, EOF with golden crc32PCIe output -> frame_done one cycle after EOF, crc_ok=1, crc_err=0, frame_count=1, err_count=0.
REQ-035 Same frame, EOF CRC with bit 0 flipped -> crc_err=1, crc_ok=0, err_count=1, crc_calc = golden value.
REQ-036 Beat without SOF in IDLE, then SOF mid-frame -> proto_err pulses each time; second frame completes with crc_ok=1.
REQ-037 MAX_WORDS=4, five payload words -> proto_err on fifth, no frame_done, state IDLE.
REQ-038 rst=1 for one cycle after two payload words, then full 5-random-word frame -> no result for aborted frame; new frame crc_ok=1, frame_count=1.
REQ-039 Back-to-back frames with in_valid held high -> in_ready=0 exactly in RESULT cycle, no beat lost; err_count held at 0xFFFF once saturated (preload by forcing 65535 errors or bench shortcut).
